// File: rtl/register_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regs_wb_pkg
// Description : Shared types for the register write-back arbiter slice.
//               Register address/data types, default widths and the
//               write-back source tag used for arbitration and debug.
// Revision    : 1.0  initial release
// ============================================================================
package regs_wb_pkg;

    localparam int C_ADDR_W = 5;
    localparam int C_DATA_W = 32;

    typedef logic [C_ADDR_W-1:0] reg_addr_t;
    typedef logic [C_DATA_W-1:0] reg_data_t;

    // Which source owns the write stage in a given cycle.
    typedef enum logic [1:0] {
        WbNone = 2'd0,
        WbExe  = 2'd1,
        WbLoad = 2'd2
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/register_writeback_arbiter_load_dest_fifo.sv
`default_nettype none
// ============================================================================
// Module      : load_dest_fifo
// Description : Depth-parameterised FIFO of load destination registers.
//               Exposes the head entry, full/empty and every slot with its
//               valid bit so the owner can search for pending destinations.
// Ports       : clk, rst          clock / synchronous active-high reset
//               push, push_data   allocate an entry (ignored when full)
//               pop               release the head entry (ignored when empty)
//               head              oldest destination
//               full, empty       occupancy flags
//               entries_flat      all slots, slot i at [i*WIDTH +: WIDTH]
//               entries_valid     per-slot occupancy
// Revision    : 1.0  initial release
// ============================================================================
module load_dest_fifo
    import regs_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = C_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH*WIDTH-1:0]   entries_flat,
    output logic [DEPTH-1:0]         entries_valid
);

    localparam int C_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_COUNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_COUNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [C_PTR_W-1:0] next_ptr(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (r_count == C_COUNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd_ptr];

    // Storage needs no reset: a slot is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            // Push and pop never target the same slot: push is blocked when
            // full and pop is blocked when empty.
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign entries_flat[gi*WIDTH +: WIDTH] = r_mem[gi];
            assign entries_valid[gi]               = r_valid[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/register_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_writeback_arbiter
// Description : Sole owner of the register file write port. Arbitrates
//               between single-cycle execute results and in-order load
//               returns, tracks outstanding load destinations and raises a
//               hazard for decode when a source register is unresolved.
// Ports       : clk, rst                  clock / sync active-high reset
//               exe_valid/ready/rd/data   execute result offer
//               ld_issue_valid/ready/rd   load destination allocation
//               ld_ret_valid/data         load data return (never stalled)
//               rs1, rs2, hazard          decode hazard query
//               rd, rd_write_enable,
//               rd_data_in                registered register-file write port
//               ld_ret_error              sticky: return with empty queue
// Revision    : 1.0  initial release
// ============================================================================
module register_writeback_arbiter
    import regs_wb_pkg::*;
#(
    parameter int ADDRESS_BIT_WIDTH = C_ADDR_W,
    parameter int DATA_BIT_WIDTH    = C_DATA_W,
    parameter int LOAD_QUEUE_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         exe_valid,
    output logic                         exe_ready,
    input  logic [ADDRESS_BIT_WIDTH-1:0] exe_rd,
    input  logic [DATA_BIT_WIDTH-1:0]    exe_data,
    input  logic                         ld_issue_valid,
    output logic                         ld_issue_ready,
    input  logic [ADDRESS_BIT_WIDTH-1:0] ld_issue_rd,
    input  logic                         ld_ret_valid,
    input  logic [DATA_BIT_WIDTH-1:0]    ld_ret_data,
    input  logic [ADDRESS_BIT_WIDTH-1:0] rs1,
    input  logic [ADDRESS_BIT_WIDTH-1:0] rs2,
    output logic                         hazard,
    output logic [ADDRESS_BIT_WIDTH-1:0] rd,
    output logic                         rd_write_enable,
    output logic [DATA_BIT_WIDTH-1:0]    rd_data_in,
    output logic                         ld_ret_error
);

    localparam int AW = ADDRESS_BIT_WIDTH;

    logic [AW-1:0]                  w_head;
    logic                           w_full;
    logic                           w_empty;
    logic [LOAD_QUEUE_DEPTH*AW-1:0] w_entries_flat;
    logic [LOAD_QUEUE_DEPTH-1:0]    w_entries_valid;

    logic    w_push;
    logic    w_pop;
    logic    w_ret_orphan;
    logic    w_exe_match;
    logic    w_rs1_match;
    logic    w_rs2_match;
    logic    w_exe_pending;
    logic    w_rs1_pending;
    logic    w_rs2_pending;
    logic    w_rs1_hazard;
    logic    w_rs2_hazard;
    wb_src_e w_src;

    logic [AW-1:0]             r_rd;
    logic                      r_we;
    logic [DATA_BIT_WIDTH-1:0] r_data;
    logic                      r_err;

    // A return with nothing outstanding has no destination: flag it, write nothing.
    assign w_pop        = ld_ret_valid && !w_empty;
    assign w_ret_orphan = ld_ret_valid && w_empty;

    // Full blocks issue even if a pop frees a slot this cycle, keeping the
    // ready path independent of the return.
    assign ld_issue_ready = !w_full;
    assign w_push         = ld_issue_valid && ld_issue_ready;

    load_dest_fifo #(
        .DEPTH (LOAD_QUEUE_DEPTH),
        .WIDTH (AW)
    ) u_load_dest_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (w_push),
        .push_data     (ld_issue_rd),
        .pop           (w_pop),
        .head          (w_head),
        .full          (w_full),
        .empty         (w_empty),
        .entries_flat  (w_entries_flat),
        .entries_valid (w_entries_valid)
    );

    // Search every occupied slot; duplicates keep a register pending until
    // the last matching entry pops.
    always_comb begin
        w_exe_match = 1'b0;
        w_rs1_match = 1'b0;
        w_rs2_match = 1'b0;
        for (int i = 0; i < LOAD_QUEUE_DEPTH; i++) begin
            if (w_entries_valid[i]) begin
                if (w_entries_flat[i*AW +: AW] == exe_rd) w_exe_match = 1'b1;
                if (w_entries_flat[i*AW +: AW] == rs1)    w_rs1_match = 1'b1;
                if (w_entries_flat[i*AW +: AW] == rs2)    w_rs2_match = 1'b1;
            end
        end
    end

    assign w_exe_pending = w_exe_match && (exe_rd != '0);
    assign w_rs1_pending = w_rs1_match && (rs1 != '0);
    assign w_rs2_pending = w_rs2_match && (rs2 != '0);

    // Holding execute off a pending destination keeps its write behind the
    // older load (no WAW reorder).
    assign exe_ready = !ld_ret_valid && !w_exe_pending;

    // The write-stage term covers the cycle before the register file commits.
    assign w_rs1_hazard = (rs1 != '0) && (w_rs1_pending || (r_we && (r_rd == rs1)));
    assign w_rs2_hazard = (rs2 != '0) && (w_rs2_pending || (r_we && (r_rd == rs2)));
    assign hazard       = w_rs1_hazard || w_rs2_hazard;

    always_comb begin
        w_src = WbNone;
        if (w_pop) begin
            w_src = WbLoad;
        end else if (exe_valid && exe_ready) begin
            w_src = WbExe;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd   <= '0;
            r_we   <= 1'b0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            case (w_src)
                WbLoad: begin
                    r_rd   <= w_head;
                    r_data <= ld_ret_data;
                    r_we   <= (w_head != '0);
                end
                WbExe: begin
                    r_rd   <= exe_rd;
                    r_data <= exe_data;
                    r_we   <= (exe_rd != '0);
                end
                default: begin
                    r_we   <= 1'b0;
                end
            endcase
            if (w_ret_orphan) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rd              = r_rd;
    assign rd_write_enable = r_we;
    assign rd_data_in      = r_data;
    assign ld_ret_error    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_register_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_writeback_arbiter
// Description : Self-checking bench for register_writeback_arbiter.
//               Directed scenarios plus a randomized run against a
//               queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_register_writeback_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          exe_valid;
    logic          exe_ready;
    logic [AW-1:0] exe_rd;
    logic [DW-1:0] exe_data;
    logic          ld_issue_valid;
    logic          ld_issue_ready;
    logic [AW-1:0] ld_issue_rd;
    logic          ld_ret_valid;
    logic [DW-1:0] ld_ret_data;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          hazard;
    logic [AW-1:0] rd;
    logic          rd_write_enable;
    logic [DW-1:0] rd_data_in;
    logic          ld_ret_error;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_q[$];
    logic [AW-1:0] m_rd;
    logic          m_we;
    logic [DW-1:0] m_data;
    logic          m_err;

    register_writeback_arbiter #(
        .ADDRESS_BIT_WIDTH (AW),
        .DATA_BIT_WIDTH    (DW),
        .LOAD_QUEUE_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .exe_valid       (exe_valid),
        .exe_ready       (exe_ready),
        .exe_rd          (exe_rd),
        .exe_data        (exe_data),
        .ld_issue_valid  (ld_issue_valid),
        .ld_issue_ready  (ld_issue_ready),
        .ld_issue_rd     (ld_issue_rd),
        .ld_ret_valid    (ld_ret_valid),
        .ld_ret_data     (ld_ret_data),
        .rs1             (rs1),
        .rs2             (rs2),
        .hazard          (hazard),
        .rd              (rd),
        .rd_write_enable (rd_write_enable),
        .rd_data_in      (rd_data_in),
        .ld_ret_error    (ld_ret_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_valid      = 1'b0;
        exe_rd         = '0;
        exe_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
        ld_ret_valid   = 1'b0;
        ld_ret_data    = '0;
        rs1            = '0;
        rs2            = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic bit model_pending(input int r);
        if (r == 0) return 1'b0;
        foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({rd, rd_write_enable, rd_data_in, ld_ret_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%0d we=%b data=%h err=%b required all zero",
                     rd, rd_write_enable, rd_data_in, ld_ret_error);
        end
        checks++;
        if (ld_issue_ready !== 1'b1 || exe_ready !== 1'b1 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: issue_ready=%b exe_ready=%b hazard=%b required 1 1 0",
                     ld_issue_ready, exe_ready, hazard);
        end
    endtask

    task automatic test_exe_write();
        exe_valid = 1'b1; exe_rd = 5'd5; exe_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (exe_ready !== 1'b1) begin
            errors++; $display("FAIL exe_ready_idle: got %b required 1", exe_ready);
        end
        tick();
        idle();
        checks++;
        if (rd !== 5'd5 || rd_write_enable !== 1'b1 || rd_data_in !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL exe_write: rd=%0d we=%b data=%h required 5 1 deadbeef",
                     rd, rd_write_enable, rd_data_in);
        end
        tick();
        checks++;
        if (rd !== 5'd5 || rd_write_enable !== 1'b0 || rd_data_in !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL exe_hold: rd=%0d we=%b data=%h required 5 0 deadbeef",
                     rd, rd_write_enable, rd_data_in);
        end
    endtask

    task automatic test_load_hazard();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
        tick();
        idle();
        rs1 = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (hazard !== 1'b1) begin
                errors++; $display("FAIL load_pending_hazard: cycle %0d got %b required 1", k, hazard);
            end
            tick();
        end
        ld_ret_valid = 1'b1; ld_ret_data = 32'h1234;
        tick();
        ld_ret_valid = 1'b0;
        checks++;
        if (rd !== 5'd7 || rd_write_enable !== 1'b1 || rd_data_in !== 32'h1234) begin
            errors++;
            $display("FAIL load_write: rd=%0d we=%b data=%h required 7 1 1234",
                     rd, rd_write_enable, rd_data_in);
        end
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++; $display("FAIL write_stage_hazard: got %b required 1", hazard);
        end
        tick();
        checks++;
        if (hazard !== 1'b0) begin
            errors++; $display("FAIL hazard_clear: got %b required 0", hazard);
        end
        idle();
    endtask

    task automatic test_waw_block();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd3;
        tick();
        idle();
        exe_valid = 1'b1; exe_rd = 5'd3; exe_data = 32'hAAAA_5555;
        #1;
        checks++;
        if (exe_ready !== 1'b0) begin
            errors++; $display("FAIL waw_block: exe_ready=%b required 0", exe_ready);
        end
        tick();
        checks++;
        if (rd_write_enable !== 1'b0) begin
            errors++; $display("FAIL waw_no_write: we=%b required 0", rd_write_enable);
        end
        ld_ret_valid = 1'b1; ld_ret_data = 32'h33;
        tick();
        ld_ret_valid = 1'b0;
        checks++;
        if (rd !== 5'd3 || rd_write_enable !== 1'b1 || rd_data_in !== 32'h33) begin
            errors++;
            $display("FAIL waw_load_first: rd=%0d we=%b data=%h required 3 1 33",
                     rd, rd_write_enable, rd_data_in);
        end
        #1;
        checks++;
        if (exe_ready !== 1'b1) begin
            errors++; $display("FAIL waw_release: exe_ready=%b required 1", exe_ready);
        end
        tick();
        idle();
        checks++;
        if (rd !== 5'd3 || rd_write_enable !== 1'b1 || rd_data_in !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL waw_exe_last: rd=%0d we=%b data=%h required 3 1 aaaa5555",
                     rd, rd_write_enable, rd_data_in);
        end
        tick();
    endtask

    task automatic test_priority();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd2;
        tick();
        idle();
        ld_ret_valid = 1'b1; ld_ret_data = 32'h77;
        exe_valid = 1'b1; exe_rd = 5'd9; exe_data = 32'h99;
        #1;
        checks++;
        if (exe_ready !== 1'b0) begin
            errors++; $display("FAIL prio_exe_ready: got %b required 0", exe_ready);
        end
        tick();
        ld_ret_valid = 1'b0;
        checks++;
        if (rd !== 5'd2 || rd_write_enable !== 1'b1 || rd_data_in !== 32'h77) begin
            errors++;
            $display("FAIL prio_load_first: rd=%0d we=%b data=%h required 2 1 77",
                     rd, rd_write_enable, rd_data_in);
        end
        tick();
        idle();
        checks++;
        if (rd !== 5'd9 || rd_write_enable !== 1'b1 || rd_data_in !== 32'h99) begin
            errors++;
            $display("FAIL prio_exe_next: rd=%0d we=%b data=%h required 9 1 99",
                     rd, rd_write_enable, rd_data_in);
        end
        tick();
    endtask

    task automatic test_full_dup_x0();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd4;
        tick();
        #1;
        checks++;
        if (ld_issue_ready !== 1'b1) begin
            errors++; $display("FAIL one_entry_ready: got %b required 1", ld_issue_ready);
        end
        tick();
        // Queue full with {4,4}; attempt a push of 6 while popping.
        ld_issue_rd = 5'd6; rs1 = 5'd4; rs2 = 5'd6;
        ld_ret_valid = 1'b1; ld_ret_data = 32'h41;
        #1;
        checks++;
        if (ld_issue_ready !== 1'b0 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL full_ready: issue_ready=%b hazard=%b required 0 1", ld_issue_ready, hazard);
        end
        tick();
        ld_issue_valid = 1'b0; ld_ret_valid = 1'b0; rs2 = 5'd0;
        checks++;
        if (rd !== 5'd4 || rd_write_enable !== 1'b1 || rd_data_in !== 32'h41) begin
            errors++;
            $display("FAIL dup_pop1: rd=%0d we=%b data=%h required 4 1 41",
                     rd, rd_write_enable, rd_data_in);
        end
        rs2 = 5'd6;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++; $display("FAIL dup_still_pending: hazard=%b required 1", hazard);
        end
        rs1 = 5'd0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++; $display("FAIL rejected_push_absent: hazard=%b required 0", hazard);
        end
        rs1 = 5'd4; rs2 = 5'd0;
        tick();
        ld_ret_valid = 1'b1; ld_ret_data = 32'h42;
        tick();
        ld_ret_valid = 1'b0;
        #1;
        checks++;
        if (rd !== 5'd4 || rd_data_in !== 32'h42 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL dup_pop2: rd=%0d data=%h hazard=%b required 4 42 1", rd, rd_data_in, hazard);
        end
        tick();
        checks++;
        if (hazard !== 1'b0 || ld_issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL dup_clear: hazard=%b issue_ready=%b required 0 1", hazard, ld_issue_ready);
        end
        // Load to x0 occupies a slot but never writes.
        idle();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (exe_ready !== 1'b1 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL x0_not_pending: exe_ready=%b hazard=%b required 1 0", exe_ready, hazard);
        end
        ld_ret_valid = 1'b1; ld_ret_data = 32'h55;
        tick();
        idle();
        checks++;
        if (rd_write_enable !== 1'b0 || rd !== 5'd0 || rd_data_in !== 32'h55 || ld_ret_error !== 1'b0) begin
            errors++;
            $display("FAIL x0_pop: we=%b rd=%0d data=%h err=%b required 0 0 55 0",
                     rd_write_enable, rd, rd_data_in, ld_ret_error);
        end
        tick();
    endtask

    task automatic test_ret_error_and_reset();
        ld_ret_valid = 1'b1; ld_ret_data = 32'hBAD;
        tick();
        idle();
        checks++;
        if (ld_ret_error !== 1'b1 || rd_write_enable !== 1'b0 || rd_data_in !== 32'h55) begin
            errors++;
            $display("FAIL orphan_return: err=%b we=%b data=%h required 1 0 55",
                     ld_ret_error, rd_write_enable, rd_data_in);
        end
        tick();
        tick();
        checks++;
        if (ld_ret_error !== 1'b1) begin
            errors++; $display("FAIL error_sticky: err=%b required 1", ld_ret_error);
        end
        // Reset with loads in flight.
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd8;
        tick();
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs1 = 5'd8;
        #1;
        checks++;
        if ({rd, rd_write_enable, rd_data_in, ld_ret_error} !== '0 || ld_issue_ready !== 1'b1 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rd=%0d we=%b data=%h err=%b ready=%b hazard=%b required 0 0 0 0 1 0",
                     rd, rd_write_enable, rd_data_in, ld_ret_error, ld_issue_ready, hazard);
        end
        // Issue and return together on an empty queue: error, no write, push kept.
        idle();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd10;
        ld_ret_valid = 1'b1; ld_ret_data = 32'hF00D;
        tick();
        idle();
        rs1 = 5'd10;
        #1;
        checks++;
        if (ld_ret_error !== 1'b1 || rd_write_enable !== 1'b0 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL issue_ret_empty: err=%b we=%b hazard=%b required 1 0 1",
                     ld_ret_error, rd_write_enable, hazard);
        end
        ld_ret_valid = 1'b1; ld_ret_data = 32'hCAFE;
        tick();
        idle();
        checks++;
        if (rd !== 5'd10 || rd_write_enable !== 1'b1 || rd_data_in !== 32'hCAFE) begin
            errors++;
            $display("FAIL kept_push_pops: rd=%0d we=%b data=%h required 10 1 cafe",
                     rd, rd_write_enable, rd_data_in);
        end
        tick();
    endtask

    task automatic test_random();
        bit  exp_exe_ready;
        bit  exp_issue_ready;
        bit  exp_hazard;
        bit  full_now;
        int  head;
        do_reset();
        m_q.delete();
        m_rd = '0; m_we = 1'b0; m_data = '0; m_err = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exe_valid      = 1'($urandom_range(0, 1));
            exe_rd         = AW'($urandom_range(0, 7));
            exe_data       = $urandom;
            ld_issue_valid = 1'($urandom_range(0, 1));
            ld_issue_rd    = AW'($urandom_range(0, 7));
            ld_ret_valid   = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            ld_ret_data    = $urandom;
            rs1            = AW'($urandom_range(0, 7));
            rs2            = AW'($urandom_range(0, 7));
            #1;
            full_now        = (m_q.size() == DEPTH);
            exp_issue_ready = !full_now;
            exp_exe_ready   = !ld_ret_valid && !model_pending(int'(exe_rd));
            exp_hazard      = 1'b0;
            if (rs1 != 0 && (model_pending(int'(rs1)) || (m_we && m_rd == rs1))) exp_hazard = 1'b1;
            if (rs2 != 0 && (model_pending(int'(rs2)) || (m_we && m_rd == rs2))) exp_hazard = 1'b1;
            checks++;
            if (exe_ready !== exp_exe_ready || ld_issue_ready !== exp_issue_ready || hazard !== exp_hazard) begin
                errors++;
                $display("FAIL rand_comb cyc %0d: exe_ready=%b issue_ready=%b hazard=%b required %b %b %b",
                         cyc, exe_ready, ld_issue_ready, hazard, exp_exe_ready, exp_issue_ready, exp_hazard);
            end
            // Advance the model one cycle.
            if (ld_ret_valid) begin
                if (m_q.size() > 0) begin
                    head   = m_q.pop_front();
                    m_rd   = AW'(head);
                    m_data = ld_ret_data;
                    m_we   = (head != 0);
                end else begin
                    m_err = 1'b1;
                    m_we  = 1'b0;
                end
            end else if (exe_valid && exp_exe_ready) begin
                m_rd   = exe_rd;
                m_data = exe_data;
                m_we   = (exe_rd != 0);
            end else begin
                m_we = 1'b0;
            end
            if (ld_issue_valid && !full_now) m_q.push_back(int'(ld_issue_rd));
            tick();
            checks++;
            if (rd !== m_rd || rd_write_enable !== m_we || rd_data_in !== m_data || ld_ret_error !== m_err) begin
                errors++;
                $display("FAIL rand_write cyc %0d: rd=%0d we=%b data=%h err=%b required %0d %b %h %b",
                         cyc, rd, rd_write_enable, rd_data_in, ld_ret_error, m_rd, m_we, m_data, m_err);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_exe_write();
        test_load_hazard();
        test_waw_block();
        test_priority();
        test_full_dup_x0();
        test_ret_error_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
